// File: rtl/bn_pkg.sv
// ============================================================================
// bn_pkg : shared types, Q-format defaults and saturation helper for the
//          batch-normalisation forward unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bn_pkg;

  localparam int BN_IL = 8;
  localparam int BN_FL = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUM  = 3'd1,
    STAT = 3'd2,
    SQRT = 3'd3,
    NORM = 3'd4,
    DONE = 3'd5
  } state_t;

  // Clamp a wide signed value into a w-bit two's-complement range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fx_sqrt.sv
// ============================================================================
// fx_sqrt : iterative radix-2 integer square root, one result bit per cycle,
//           fixed latency of (IL+2*FL)/2 cycles counted from the start cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fx_sqrt
  import bn_pkg::*;
#(
  parameter int IL = BN_IL,
  parameter int FL = BN_FL
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [IL+2*FL-1:0]         radicand,
  output logic                       busy,
  output logic                       done,
  output logic [(IL+2*FL)/2-1:0]     root
);

  localparam int RW = IL + 2 * FL;
  localparam int N  = RW / 2;
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]  r_cnt;
  logic [RW-1:0]  r_rad;
  logic [N+1:0]   r_rem;
  logic [N-1:0]   r_root;

  logic [RW-1:0]  w_rad_src, w_rad_nx;
  logic [N+1:0]   w_rem_src, w_rem_nx;
  logic [N-1:0]   w_root_src, w_root_nx;
  logic [N+3:0]   w_rem_sh, w_trial;

  // The start cycle already performs the first iteration on the raw inputs.
  always_comb begin
    w_rad_src  = busy ? r_rad  : radicand;
    w_rem_src  = busy ? r_rem  : '0;
    w_root_src = busy ? r_root : '0;
    w_rem_sh   = {w_rem_src, w_rad_src[RW-1 -: 2]};
    w_trial    = {2'b00, w_root_src, 2'b01};
    w_rad_nx   = {w_rad_src[RW-3:0], 2'b00};
    if (w_rem_sh >= w_trial) begin
      w_rem_nx  = w_rem_sh[N+1:0] - w_trial[N+1:0];
      w_root_nx = {w_root_src[N-2:0], 1'b1};
    end else begin
      w_rem_nx  = w_rem_sh[N+1:0];
      w_root_nx = {w_root_src[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      r_cnt  <= '0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
    end else if (busy || start) begin
      r_rad  <= w_rad_nx;
      r_rem  <= w_rem_nx;
      r_root <= w_root_nx;
      if (!busy) begin
        busy  <= 1'b1;
        r_cnt <= CW'(1);
      end else if (r_cnt == CW'(N - 1)) begin
        busy  <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign done = busy && (r_cnt == CW'(N - 1));
  assign root = r_root;

endmodule

`default_nettype wire

// File: rtl/bn_fwd_multi.sv
// ============================================================================
// bn_fwd_multi : multi-channel batch-norm forward unit, one sample per cycle,
//                training (batch stats) or inference (running stats).
// Revision: 1.0
// ============================================================================
`default_nettype none

module bn_fwd_multi
  import bn_pkg::*;
#(
  parameter int IL     = BN_IL,
  parameter int FL     = BN_FL,
  parameter int SIZE   = 16,
  parameter int CH     = 4,
  parameter int MOM_SH = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        mode,
  input  logic [$clog2(SIZE):0]       num,
  input  logic signed [IL+FL-1:0]     batch [CH][SIZE],
  input  logic signed [IL+FL-1:0]     gamma [CH],
  input  logic signed [IL+FL-1:0]     beta  [CH],
  output logic signed [IL+FL-1:0]     out   [CH][SIZE],
  output logic signed [IL+FL-1:0]     mu    [CH],
  output logic signed [IL+FL-1:0]     vari  [CH],
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int W  = IL + FL;
  localparam int SW = $clog2(SIZE);
  localparam int NW = SW + 1;
  localparam int AW = W + SW + 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int RW = IL + 2 * FL;
  localparam int RN = RW / 2;
  localparam int DW = W + FL + 1;

  state_t                r_state;
  logic                  r_mode;
  logic [NW-1:0]         r_num, r_k, w_num_cl;
  logic [CW-1:0]         r_ch, w_ch_nx;
  logic signed [AW-1:0]  r_s, r_q, w_div;
  logic signed [W-1:0]   r_batch [CH][SIZE];
  logic signed [W-1:0]   r_gamma [CH], r_beta [CH], r_rm [CH], r_rv [CH];

  logic signed [W-1:0]   w_x, w_sq, w_mu_new, w_musq, w_qm, w_var_new, w_rm_new, w_rv_new;
  logic signed [W-1:0]   w_norm, w_o;
  logic signed [2*W-1:0] w_xx, w_mm, w_gn;
  logic signed [W:0]     w_var_d;
  logic signed [DW-1:0]  w_nn, w_den, w_quo;
  logic [RW-1:0]         w_rad;
  logic [RN-1:0]         w_root;
  logic                  w_sq_start, w_sq_busy, w_sq_done, w_last_k, w_last_ch;

  always_comb begin
    w_num_cl  = (num == '0) ? NW'(1) : ((num > NW'(SIZE)) ? NW'(SIZE) : num);
    w_last_k  = (r_k == r_num - NW'(1));
    w_last_ch = (r_ch == CW'(CH - 1));
    w_ch_nx   = r_ch + CW'(1);
    w_x       = r_batch[r_ch][r_k[SW-1:0]];
    w_xx      = w_x * w_x;
    w_sq      = W'(sat(64'(w_xx >>> FL), W));
    // Batch statistics: truncating signed division by the clamped count.
    w_div     = $signed({{(AW-NW){1'b0}}, r_num});
    w_mu_new  = W'(sat(64'(r_s / w_div), W));
    w_qm      = W'(sat(64'(r_q / w_div), W));
    w_mm      = w_mu_new * w_mu_new;
    w_musq    = W'(sat(64'(w_mm >>> FL), W));
    w_var_d   = (W+1)'(w_qm) - (W+1)'(w_musq);
    w_var_new = w_var_d[W] ? '0 : w_var_d[W-1:0];
    w_rm_new  = W'(sat(64'(r_rm[r_ch]) + ((64'(w_mu_new) - 64'(r_rm[r_ch])) >>> MOM_SH), W));
    w_rv_new  = W'(sat(64'(r_rv[r_ch]) + ((64'(w_var_new) - 64'(r_rv[r_ch])) >>> MOM_SH), W));
    // The +1 LSB epsilon keeps the root away from zero.
    w_rad     = (RW'($unsigned(vari[r_ch])) + RW'(1)) << FL;
    w_nn      = (DW'(w_x) - DW'(mu[r_ch])) <<< FL;
    w_den     = $signed(DW'(w_root));
    w_quo     = w_nn / w_den;
    w_norm    = W'(sat(64'(w_quo), W));
    w_gn      = r_gamma[r_ch] * w_norm;
    w_o       = W'(sat(64'(w_gn >>> FL) + 64'(r_beta[r_ch]), W));
    w_sq_start = (r_state == SQRT) && !w_sq_busy;
  end

  fx_sqrt #(.IL(IL), .FL(FL)) u_sqrt (
    .clk      (clk),
    .reset    (reset),
    .start    (w_sq_start),
    .radicand (w_rad),
    .busy     (w_sq_busy),
    .done     (w_sq_done),
    .root     (w_root)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r_mode    <= 1'b0;
      r_num     <= NW'(1);
      r_k       <= '0;
      r_ch      <= '0;
      r_s       <= '0;
      r_q       <= '0;
      for (int c = 0; c < CH; c++) begin
        r_gamma[c] <= '0;
        r_beta[c]  <= '0;
        r_rm[c]    <= '0;
        r_rv[c]    <= W'(1) << FL;
        mu[c]      <= '0;
        vari[c]    <= '0;
        for (int k = 0; k < SIZE; k++) begin
          r_batch[c][k] <= '0;
          out[c][k]     <= '0;
        end
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_batch  <= batch;
            r_gamma  <= gamma;
            r_beta   <= beta;
            r_mode   <= mode;
            r_num    <= w_num_cl;
            r_k      <= '0;
            r_ch     <= '0;
            r_s      <= '0;
            r_q      <= '0;
            in_ready <= 1'b0;
            for (int c = 0; c < CH; c++)
              for (int k = 0; k < SIZE; k++)
                out[c][k] <= '0;
            if (mode) begin
              mu[0]   <= r_rm[0];
              vari[0] <= r_rv[0];
              r_state <= SQRT;
            end else begin
              r_state <= SUM;
            end
          end
        end
        SUM: begin
          r_s <= r_s + AW'(w_x);
          r_q <= r_q + AW'(w_sq);
          if (w_last_k) begin
            r_k     <= '0;
            r_state <= STAT;
          end else begin
            r_k <= r_k + NW'(1);
          end
        end
        STAT: begin
          mu[r_ch]   <= w_mu_new;
          vari[r_ch] <= w_var_new;
          r_rm[r_ch] <= w_rm_new;
          r_rv[r_ch] <= w_rv_new;
          r_state    <= SQRT;
        end
        SQRT: begin
          if (w_sq_done) r_state <= NORM;
        end
        NORM: begin
          out[r_ch][r_k[SW-1:0]] <= w_o;
          if (!w_last_k) begin
            r_k <= r_k + NW'(1);
          end else begin
            r_k <= '0;
            if (w_last_ch) begin
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_ch <= w_ch_nx;
              r_s  <= '0;
              r_q  <= '0;
              if (r_mode) begin
                mu[w_ch_nx]   <= r_rm[w_ch_nx];
                vari[w_ch_nx] <= r_rv[w_ch_nx];
                r_state       <= SQRT;
              end else begin
                r_state <= SUM;
              end
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bn_fwd_multi.sv
// ============================================================================
// tb_bn_fwd_multi : directed vector table plus hand-written handshake,
//                   latency and mid-operation reset sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bn_fwd_multi;

  localparam int IL = 8, FL = 12, SIZE = 16, CH = 4, MOM_SH = 3;
  localparam int W = IL + FL;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                mode_i = 1'b0;
  logic [4:0]          num_i = '0;
  logic signed [W-1:0] batch_i [CH][SIZE];
  logic signed [W-1:0] gamma_i [CH];
  logic signed [W-1:0] beta_i  [CH];
  logic signed [W-1:0] out_o   [CH][SIZE];
  logic signed [W-1:0] mu_o    [CH];
  logic signed [W-1:0] vari_o  [CH];
  logic                out_valid;
  logic                out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bn_fwd_multi #(.IL(IL), .FL(FL), .SIZE(SIZE), .CH(CH), .MOM_SH(MOM_SH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode_i),
    .num       (num_i),
    .batch     (batch_i),
    .gamma     (gamma_i),
    .beta      (beta_i),
    .out       (out_o),
    .mu        (mu_o),
    .vari      (vari_o),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    bit rst;
    bit mode;
    int num;
    int x0, x1, g, b;
    int mu, vari, o0, o1, nv, tol;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int d;
    total++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input bit md, input int n, input int x0, input int x1, input int g, input int b);
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < SIZE; k++) batch_i[c][k] = W'((k % 2 == 0) ? x0 : x1);
      gamma_i[c] = W'(g);
      beta_i[c]  = W'(b);
    end
    mode_i = md;
    num_i  = 5'(n);
  endtask

  task automatic start_op();
    chk("in_ready_idle", int'(in_ready), 1, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until out_valid is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (out_valid !== 1'b1) chk("done_timeout", int'(out_valid), 1, 0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_accept", int'(in_ready), 1, 0);
    chk("out_valid_after_accept", int'(out_valid), 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int expv;
    //            rst mode num  x0      x1       g      b      mu    vari  o0      o1      nv  tol
    vecs[0] = '{1'b1, 1'b0, 2,  4096,   12288,   4096,  0,     8192, 4096, -4096,  4096,   2,  1};
    vecs[1] = '{1'b0, 1'b1, 2,  1024,   1024,    4096,  300,   1024, 4096, 300,    300,    2,  0};
    vecs[2] = '{1'b1, 1'b0, 16, 8192,   8192,    4096,  1000,  8192, 0,    1000,   1000,   16, 0};
    vecs[3] = '{1'b0, 1'b1, 16, 1024,   1024,    4096,  77,    1024, 3584, 77,     77,     16, 0};
    vecs[4] = '{1'b1, 1'b1, 2,  2048,   2048,    8192,  1024,  0,    4096, 5120,   5120,   2,  1};
    vecs[5] = '{1'b1, 1'b0, 0,  4096,   999,     4096,  -2048, 4096, 0,    -2048,  0,      1,  0};
    vecs[6] = '{1'b1, 1'b0, 3,  0,      4096,    4096,  0,     1365, 911,  -2893,  5789,   3,  1};
    vecs[7] = '{1'b1, 1'b1, 20, 524287, -524288, 16384, 0,     0,    4096, 524287, -524288, 16, 0};

    load(1'b0, 1, 0, 0, 0, 0);
    do_reset();
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_mu0", int'(mu_o[0]), 0, 0);
    chk("rst_vari3", int'(vari_o[3]), 0, 0);
    chk("rst_out15", int'(out_o[1][5]), 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      load(vecs[i].mode, vecs[i].num, vecs[i].x0, vecs[i].x1, vecs[i].g, vecs[i].b);
      start_op();
      wait_done(cyc);
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("v%0d_mu[%0d]", i, c), int'(mu_o[c]), vecs[i].mu, 0);
        chk($sformatf("v%0d_vari[%0d]", i, c), int'(vari_o[c]), vecs[i].vari, 0);
        for (int k = 0; k < SIZE; k++) begin
          expv = (k >= vecs[i].nv) ? 0 : ((k % 2 == 0) ? vecs[i].o0 : vecs[i].o1);
          chk($sformatf("v%0d_out[%0d][%0d]", i, c, k), int'(out_o[c][k]), expv,
              (k >= vecs[i].nv) ? 0 : vecs[i].tol);
        end
      end
      release_out();
    end

    // Latency and stalled consumer. 196 edges after the accept edge is the
    // 197th cycle when the accept cycle itself is numbered 0.
    do_reset();
    load(1'b0, 16, 8192, 8192, 4096, 1000);
    start_op();
    wait_done(cyc);
    chk("latency_train16", cyc, 196, 0);
    in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk($sformatf("hold_out_valid_t%0d", t), int'(out_valid), 1, 0);
      chk($sformatf("hold_in_ready_t%0d", t), int'(in_ready), 0, 0);
      chk($sformatf("hold_out00_t%0d", t), int'(out_o[0][0]), 1000, 0);
      chk($sformatf("hold_out3f_t%0d", t), int'(out_o[3][15]), 1000, 0);
    end
    in_valid = 1'b0;
    release_out();

    // Reset during SQRT must also restore the running statistics.
    do_reset();
    load(1'b0, 2, 4096, 12288, 4096, 0);
    start_op();
    wait_done(cyc);
    release_out();
    start_op();
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1, 0);
    chk("midrst_out_valid", int'(out_valid), 0, 0);
    load(1'b1, 2, 1024, 1024, 4096, 0);
    start_op();
    wait_done(cyc);
    chk("midrst_rm0", int'(mu_o[0]), 0, 0);
    chk("midrst_rv0", int'(vari_o[0]), 4096, 0);
    chk("midrst_out00", int'(out_o[0][0]), 1024, 1);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
